// File: rtl/pass_sequence_gen.sv
// Two-beam pass-sequence generator: plays the four-phase {D1,D2} pattern of an
// object crossing two beams, with abort/unwind and a shadow net pass count.
module pass_sequence_gen #(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned CW           = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Dir,
  input  logic       Abort,
  output logic       Ready,
  output logic       D1,
  output logic       D2,
  output logic       Done,
  output logic       Abtd,
  output logic [2:0] Net
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_UNWIND
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] dc_q, dc_d;
  logic          dir_q, dir_d;
  logic          d1_q, d2_q;
  logic [1:0]    code_d;
  logic          done_q, done_d;
  logic          abtd_q, abtd_d;
  logic [2:0]    net_q, net_d;
  logic          dwell_end;

  // Forward table 00,10,11,01; the reverse table is the same with D1/D2 swapped.
  function automatic logic [1:0] phase_code(input logic [1:0] idx, input logic dir);
    logic [1:0] fwd;
    unique case (idx)
      2'd0:    fwd = 2'b00;
      2'd1:    fwd = 2'b10;
      2'd2:    fwd = 2'b11;
      default: fwd = 2'b01;
    endcase
    return dir ? {fwd[0], fwd[1]} : fwd;
  endfunction

  assign dwell_end = (dc_q == CW'(PHASE_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    dc_d    = dc_q + 1'b1;
    done_d  = 1'b0;
    abtd_d  = 1'b0;
    net_d   = net_q;
    unique case (state_q)
      S_IDLE: begin
        dc_d = '0;
        if (Start) begin
          state_d = S_RUN;
          idx_d   = 2'd1;
          dir_d   = Dir;
        end
      end
      S_RUN: begin
        // Abort takes priority over a coincident dwell end.
        if (Abort) begin
          state_d = S_UNWIND;
          idx_d   = idx_q - 2'd1;
          dc_d    = '0;
        end else if (dwell_end) begin
          dc_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_GAP;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_GAP: begin
        if (dwell_end) begin
          state_d = S_IDLE;
          dc_d    = '0;
          done_d  = 1'b1;
          net_d   = dir_q ? net_q - 3'd1 : net_q + 3'd1;
        end
      end
      S_UNWIND: begin
        if (dwell_end) begin
          dc_d = '0;
          if (idx_q == 2'd0) begin
            state_d = S_IDLE;
            abtd_d  = 1'b1;
          end else begin
            idx_d = idx_q - 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
        dc_d    = '0;
      end
    endcase
    code_d = phase_code(idx_d, dir_d);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      dc_q    <= '0;
      dir_q   <= 1'b0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
      done_q  <= 1'b0;
      abtd_q  <= 1'b0;
      net_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dc_q    <= dc_d;
      dir_q   <= dir_d;
      d1_q    <= code_d[1];
      d2_q    <= code_d[0];
      done_q  <= done_d;
      abtd_q  <= abtd_d;
      net_q   <= net_d;
    end
  end

  assign Ready = (state_q == S_IDLE);
  assign D1    = d1_q;
  assign D2    = d2_q;
  assign Done  = done_q;
  assign Abtd  = abtd_q;
  assign Net   = net_q;

endmodule

// File: tb/tb_pass_sequence_gen.sv
// Bench for pass_sequence_gen: directed test-plan cases plus random traffic
// checked against a per-cycle expected-waveform queue and a beam-pair counter.
module tb_pass_sequence_gen;

  localparam int unsigned N = 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic       Dir = 1'b0;
  logic       Abort = 1'b0;
  logic       Ready, D1, D2, Done, Abtd;
  logic [2:0] Net;

  pass_sequence_gen #(.PHASE_CYCLES(N), .CW(8)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Start(Start),
    .Dir  (Dir),
    .Abort(Abort),
    .Ready(Ready),
    .D1   (D1),
    .D2   (D2),
    .Done (Done),
    .Abtd (Abtd),
    .Net  (Net)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] code;
    logic       rdy;
    logic       dn;
    logic       ab;
  } ent_t;

  localparam ent_t IDLE_E = 5'b00100;

  ent_t       exp_q[$];
  ent_t       cur = IDLE_E;
  int         age = 0;
  bit         busy = 0, unw = 0, mdir = 0;
  logic [2:0] net_m = '0;

  logic [1:0] hist[$];
  logic [1:0] last_code = 2'b00;
  logic [2:0] pair_cnt = '0;

  logic [15:0] pat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] code_of(input int p, input bit dr);
    logic [1:0] c;
    case (p)
      0:       c = 2'b00;
      1:       c = 2'b10;
      2:       c = 2'b11;
      default: c = 2'b01;
    endcase
    return dr ? {c[0], c[1]} : c;
  endfunction

  function automatic ent_t mk(input logic [1:0] c, input logic r, input logic dn, input logic ab);
    return {c, r, dn, ab};
  endfunction

  // Expected outputs as a queue of future cycles, rebuilt on Start or Abort.
  task automatic model_edge(input bit s, input bit d, input bit a, input bit r);
    int p;
    if (r) begin
      exp_q.delete();
      busy  = 0;
      unw   = 0;
      net_m = '0;
      cur   = IDLE_E;
      return;
    end
    if (cur.rdy && s) begin
      exp_q.delete();
      busy = 1;
      unw  = 0;
      mdir = d;
      age  = 0;
      for (int ph = 1; ph <= 3; ph++)
        repeat (N) exp_q.push_back(mk(code_of(ph, d), 1'b0, 1'b0, 1'b0));
      repeat (N) exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(2'b00, 1'b1, 1'b1, 1'b0));
    end else if (busy && !unw && a && age < int'(3 * N)) begin
      p = age / int'(N) + 1;
      exp_q.delete();
      for (int ph = p - 1; ph >= 0; ph--)
        repeat (N) exp_q.push_back(mk(code_of(ph, mdir), 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b1));
      unw = 1;
      age++;
    end else begin
      age++;
    end
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else                  cur = IDLE_E;
    if (cur.dn) net_m = mdir ? net_m - 3'd1 : net_m + 3'd1;
    if (cur.rdy) begin
      busy = 0;
      unw  = 0;
    end
  endtask

  // Independent direction counter fed only from the beam lines.
  task automatic pair_counter(input bit r);
    logic [1:0] c;
    c = {D1, D2};
    if (r) begin
      hist.delete();
      pair_cnt  = '0;
      last_code = 2'b00;
      return;
    end
    if (c != last_code) begin
      if (c == 2'b00) begin
        if (hist.size() == 3 && hist[0] == 2'b10 && hist[1] == 2'b11 && hist[2] == 2'b01)
          pair_cnt = pair_cnt + 3'd1;
        else if (hist.size() == 3 && hist[0] == 2'b01 && hist[1] == 2'b11 && hist[2] == 2'b10)
          pair_cnt = pair_cnt - 3'd1;
        hist.delete();
      end else begin
        hist.push_back(c);
      end
      last_code = c;
    end
    if (Ready) check_eq("paircnt", {29'd0, Net}, {29'd0, pair_cnt});
  endtask

  task automatic step(input bit s, input bit d, input bit a, input bit r);
    Start = s;
    Dir   = d;
    Abort = a;
    Rst   = r;
    @(posedge Clk);
    #1;
    model_edge(s, d, a, r);
    check_eq("outs", {24'd0, D1, D2, Ready, Done, Abtd, Net}, {24'd0, cur, net_m});
    pair_counter(r);
  endtask

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_eq("rst_state", {27'd0, D1, D2, Ready, Done, Abtd}, 32'b00100);
    check_eq("rst_net", {29'd0, Net}, 32'd0);

    // Forward pass; Dir toggled after acceptance must not matter.
    step(1, 0, 0, 0);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[13:0], D1, D2};
      step(0, 1, 0, 0);
    end
    check_eq("fwd_pattern", {16'd0, pat}, 32'h0000AF50);
    check_eq("fwd_done", {28'd0, Done, Net}, {28'd0, 1'b1, 3'd1});
    step(0, 0, 0, 0);
    check_eq("fwd_done_once", {31'd0, Done}, 32'd0);

    // Reverse pass from Net=0.
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[13:0], D1, D2};
      step(0, 0, 0, 0);
    end
    check_eq("rev_pattern", {16'd0, pat}, 32'h00005FA0);
    check_eq("rev_done", {28'd0, Done, Net}, {28'd0, 1'b1, 3'd7});
    step(0, 0, 0, 0);

    // Abort sampled in the first 01 cycle.
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat = {pat[13:0], D1, D2};
      step(0, 0, 0, 0);
    end
    check_eq("abort_unwind", {16'd0, pat}, 32'h00000FA0);
    check_eq("abort_abtd", {27'd0, Abtd, Done, Net}, {27'd0, 1'b1, 1'b0, 3'd7});

    // Eight back-to-back forward passes wrap Net to 0.
    step(0, 0, 0, 1);
    repeat (8 * (4 * N + 1)) step(1, 0, 0, 0);
    check_eq("wrap_net", {28'd0, Done, Net}, {28'd0, 1'b1, 3'd0});
    step(0, 0, 0, 0);

    // Start during RUN ignored, Abort in GAP ignored.
    step(1, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check_eq("gap_abort_ignored", {28'd0, Done, Net}, {28'd0, 1'b1, 3'd1});

    // Abort coinciding with the phase-1 dwell end.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check_eq("abort_dwell", {29'd0, D1, D2, Ready}, 32'd0);
    repeat (3) step(0, 0, 0, 0);

    // Reset in cycle 4 of a pass, then a fresh pass.
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check_eq("midrst", {26'd0, D1, D2, Ready, Net}, {26'd0, 3'b001, 3'd0});
    step(1, 0, 0, 0);
    repeat (4 * N) step(0, 0, 0, 0);
    check_eq("post_rst_pass", {28'd0, Done, Net}, {28'd0, 1'b1, 3'd1});

    repeat (3000)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pass_sequence_gen.md
# pass_sequence_gen

Two-beam pass-sequence generator: drives the D1/D2 sensor-pair lines with the exact four-phase pattern an object produces when it crosses two adjacent beams. It is the transmitting end of the pass-direction counter interface and produces one forward pass or one reverse pass per request. Typical uses are bench stimulus for the direction counter and self-test injection in the lab top level. Each phase is held for a programmable number of clocks. A retracting object is modelled by an abort that unwinds the sequence, so the counting end never registers a pass. A shadow net counter mirrors the value the counting end must hold.

## Interface
- PHASE_CYCLES, 4: clocks each phase is held; legal range 1..255.
- CW, 8: width of the internal dwell counter; must hold PHASE_CYCLES.
- Clk  in  1  system clock, rising-edge active.
- Rst  in  1  reset, synchronous, active-high.
- Start  in  1  pass request; sampled only while Ready=1.
- Dir  in  1  0 = forward pass ({D1,D2} 10→11→01→00), 1 = reverse pass (01→11→10→00); latched when Start is accepted.
- Abort  in  1  retract request; sampled only in RUN.
- Ready  out  1  high in IDLE (generator accepts Start).
- D1  out  1  beam-1 line, registered.
- D2  out  1  beam-2 line, registered.
- Done  out  1  one-cycle pulse: pass completed.
- Abtd  out  1  one-cycle pulse: aborted pass fully unwound.
- Net  out  3  shadow count: +1 per completed forward pass, −1 per completed reverse pass.

## Operation
- Phase table, index 0..3. Forward: 00, 10, 11, 01. Reverse: 00, 01, 11, 10. {D1,D2} always equals table[idx] of the latched Dir.
- States:
  - IDLE: idx=0, {D1,D2}=00, Ready=1.
  - RUN: idx=1..3.
  - GAP: idx=0, holding the trailing 00.
  - UNWIND: idx counts down toward 0.
- Dwell counter dc. Loaded with 0 on every phase entry. Increments every clock. The phase ends in the cycle where dc == PHASE_CYCLES−1.
- Transitions:
  - IDLE: Start=1 → RUN, idx=1, latch Dir.
  - RUN with idx<3, dwell end → RUN, idx+1.
  - RUN with idx=3, dwell end → GAP.
  - GAP, dwell end → IDLE with Done=1 for the first IDLE cycle. Net updated on the same edge.
  - RUN with Abort=1 → UNWIND with idx−1. From idx=1 the target is idx=0, so UNWIND holds 00.
  - UNWIND with idx>0, dwell end → UNWIND, idx−1.
  - UNWIND with idx=0, dwell end → IDLE with Abtd=1 for one cycle. Net unchanged.
- Every unwind step presents only adjacent codes, so the counting end returns to its start state without a count.
- Net arithmetic is 3-bit modulo 8: 7+1→0, 0−1→7.
- Boundary rules:
  - Abort and dwell end in the same cycle: Abort wins.
  - Abort in GAP, UNWIND or IDLE is ignored.
  - Start outside IDLE is ignored.
  - Start during the Done or Abtd cycle is accepted, because that cycle is already IDLE.
  - Start and Abort together in IDLE: Start accepted, Abort ignored.
  - Dir changes after acceptance have no effect.
  - PHASE_CYCLES=1: each phase lasts exactly one clock.

## Timing
- Rst=1 at an edge gives, after that edge: state IDLE, D1=D2=0, Ready=1, Done=0, Abtd=0, Net=0, dc=0. Reset mid-sequence takes effect at the same edge with no unwind.
- All outputs are registered or decoded directly from state registers; there are no combinational paths from inputs to outputs.
- Start accepted at edge k:
  - Ready=0 from k+1.
  - Phase 1 holds for cycles k+1..k+N, where N=PHASE_CYCLES.
  - Phase 2 holds for k+N+1..k+2N.
  - Phase 3 holds for k+2N+1..k+3N.
  - 00 gap holds for k+3N+1..k+4N.
  - Done=1, Ready=1 and the new Net appear in cycle k+4N+1.
- Total request-to-Done latency is 4N+1 cycles.
- Abort sampled at edge a: the previous phase code appears from cycle a+1. Each unwind phase lasts N cycles.

## Test plan
- N=2, Dir=0, Start pulse at edge 0: {D1,D2} = 10,10,11,11,01,01,00,00 in cycles 1–8. Done=1 in cycle 9 only. Net 0→1 in cycle 9.
- N=2, Dir=1: {D1,D2} = 01,01,11,11,10,10,00,00. Done in cycle 9. Net 0→7.
- N=2, Dir=0, Abort during the first 01 cycle (cycle 5): cycles 6–7 = 11, cycles 8–9 = 10, cycles 10–11 = 00. Abtd=1 in cycle 12. Done never pulses. Net unchanged.
- Eight back-to-back forward passes, with Start held high so the next pass starts in each Done cycle: Net reaches 0 after the 8th pass (wrap). There is no idle gap between Done and the next phase-1 code.
- Start during RUN, Abort in GAP, and Abort plus dwell end in the same cycle: the first two are ignored; the simultaneous case enters UNWIND.
- Rst asserted in cycle 4 of a pass: in the next cycle D1=D2=0, Ready=1, Net=0. The generator then completes a fresh forward pass normally.
- Cross-check: drive the direction counter with this generator through random Start/Dir/Abort sequences. The counter's value must always equal Net.
